vdp_hostif: RTL

VDP_HOSTIF -- requirements
Module: vdp_hostif

---
 rtl/vdp_pkg.sv | 29 ++
 rtl/vdp_tick_pacer.sv | 32 +++
 rtl/vdp_hostif.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP host interface: command opcodes, FSM states,
// and the control-byte flags written on the VDP's mode=1 port.
package vdp_pkg;

    typedef enum logic [1:0] {
        OP_REG_WR    = 2'd0,
        OP_VRAM_WR   = 2'd1,
        OP_VRAM_RD   = 2'd2,
        OP_STATUS_RD = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP_LO,
        ST_SETUP_HI,
        ST_XFER,
        ST_WAIT_GAP
    } state_t;

    // Second control byte: register select, or VRAM write-address setup
    localparam logic [7:0] MODE_REG_SEL = 8'h80;
    localparam logic [7:0] MODE_VRAM_WR = 8'h40;

    // High address byte of a VRAM setup sequence; bit 6 selects write direction
    function automatic logic [7:0] addr_hi_byte(input logic [13:0] addr, input logic is_wr);
        return (is_wr ? MODE_VRAM_WR : 8'h00) | {2'b00, addr[13:8]};
    endfunction

endpackage

// File: rtl/vdp_tick_pacer.sv
// Enforces the minimum tick-to-tick spacing of VDP port accesses.
// start is the tick itself; done is high once the next access may be issued.
module vdp_tick_pacer #(
    parameter int unsigned GAP = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    // Three cycles of the gap are structural: the tick cycle itself, the
    // WAIT_GAP cycle that sees the tick, and the issue cycle of the next tick.
    localparam int unsigned LOAD = (GAP > 3) ? GAP - 3 : 0;
    localparam int unsigned CW   = (LOAD > 1) ? $clog2(LOAD + 1) : 1;

    logic [CW-1:0] cnt;

    // Reload on every tick, then count down to zero and hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(LOAD);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vdp_hostif.sv
// Host command front-end for a TMS9918-style VDP port.
// Optional feature: define VDP_HOSTIF_IRQ_POLL_EN to add vdp_irq/vblank_tick
// and automatic status polling while idle.
module vdp_hostif
    import vdp_pkg::*;
#(
    parameter int unsigned ACCESS_GAP = 8,
    parameter int unsigned LEN_WIDTH  = 14
) (
    input  logic                 pxclk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [13:0]          cmd_addr,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [7:0]           wr_data,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    output logic [7:0]           rd_data,
    output logic                 rd_valid,
    output logic                 vdp_wr_tick,
    output logic                 vdp_rd_tick,
    output logic                 vdp_mode,
    output logic [7:0]           vdp_din,
    input  logic [7:0]           vdp_dout,
`ifdef VDP_HOSTIF_IRQ_POLL_EN
    input  logic                 vdp_irq,
    output logic                 vblank_tick,
`endif
    output logic                 busy
);

    state_t               state;
    state_t               ret_state;
    op_t                  op_q;
    logic [13:0]          addr_q;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 gap_done;
    logic                 tick_any;
`ifdef VDP_HOSTIF_IRQ_POLL_EN
    logic                 poll_q;
`endif

    assign tick_any  = vdp_wr_tick | vdp_rd_tick;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    vdp_tick_pacer #(
        .GAP (ACCESS_GAP)
    ) u_pacer (
        .clk   (pxclk),
        .rst   (reset),
        .start (tick_any),
        .done  (gap_done)
    );

    // Command sequencer: every access is issued from one state, then parks
    // in WAIT_GAP until the pacer releases it to ret_state
    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ret_state   <= ST_IDLE;
            op_q        <= OP_REG_WR;
            addr_q      <= '0;
            cnt         <= '0;
            vdp_wr_tick <= 1'b0;
            vdp_rd_tick <= 1'b0;
            vdp_mode    <= 1'b0;
            vdp_din     <= '0;
            wr_ready    <= 1'b0;
`ifdef VDP_HOSTIF_IRQ_POLL_EN
            poll_q      <= 1'b0;
`endif
        end else begin
            vdp_wr_tick <= 1'b0;
            vdp_rd_tick <= 1'b0;
            wr_ready    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q   <= op_t'(cmd_op);
                        addr_q <= cmd_addr;
                        // For REG_WR the counter carries the register value
                        cnt    <= cmd_len;
                        state  <= (op_t'(cmd_op) == OP_STATUS_RD) ? ST_XFER : ST_SETUP_LO;
`ifdef VDP_HOSTIF_IRQ_POLL_EN
                        poll_q <= 1'b0;
                    end else if (vdp_irq) begin
                        op_q   <= OP_STATUS_RD;
                        poll_q <= 1'b1;
                        state  <= ST_XFER;
`endif
                    end
                end
                ST_SETUP_LO: begin
                    vdp_wr_tick <= 1'b1;
                    vdp_mode    <= 1'b1;
                    vdp_din     <= (op_q == OP_REG_WR) ? cnt[7:0] : addr_q[7:0];
                    ret_state   <= ST_SETUP_HI;
                    state       <= ST_WAIT_GAP;
                end
                ST_SETUP_HI: begin
                    vdp_wr_tick <= 1'b1;
                    vdp_mode    <= 1'b1;
                    vdp_din     <= (op_q == OP_REG_WR) ? (MODE_REG_SEL | {5'b00000, addr_q[2:0]})
                                                       : addr_hi_byte(addr_q, op_q == OP_VRAM_WR);
                    ret_state   <= (op_q == OP_REG_WR || cnt == '0) ? ST_IDLE : ST_XFER;
                    state       <= ST_WAIT_GAP;
                end
                ST_XFER: begin
                    if (op_q == OP_VRAM_WR) begin
                        if (wr_valid) begin
                            vdp_wr_tick <= 1'b1;
                            vdp_mode    <= 1'b0;
                            vdp_din     <= wr_data;
                            wr_ready    <= 1'b1;
                            cnt         <= cnt - LEN_WIDTH'(1);
                            ret_state   <= (cnt == LEN_WIDTH'(1)) ? ST_IDLE : ST_XFER;
                            state       <= ST_WAIT_GAP;
                        end
                    end else if (op_q == OP_VRAM_RD) begin
                        vdp_rd_tick <= 1'b1;
                        vdp_mode    <= 1'b0;
                        cnt         <= cnt - LEN_WIDTH'(1);
                        ret_state   <= (cnt == LEN_WIDTH'(1)) ? ST_IDLE : ST_XFER;
                        state       <= ST_WAIT_GAP;
                    end else begin
                        vdp_rd_tick <= 1'b1;
                        vdp_mode    <= 1'b1;
                        ret_state   <= ST_IDLE;
                        state       <= ST_WAIT_GAP;
                    end
                end
                ST_WAIT_GAP: begin
                    // The pacer only reloads on the tick itself, so ignore done then
                    if (gap_done && !tick_any) begin
                        state <= ret_state;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture read data at the end of the read-tick cycle
    always_ff @(posedge pxclk or posedge reset) begin
        if (reset) begin
            rd_data     <= '0;
            rd_valid    <= 1'b0;
`ifdef VDP_HOSTIF_IRQ_POLL_EN
            vblank_tick <= 1'b0;
`endif
        end else begin
            rd_valid <= vdp_rd_tick;
            if (vdp_rd_tick) begin
                rd_data <= vdp_dout;
            end
`ifdef VDP_HOSTIF_IRQ_POLL_EN
            vblank_tick <= vdp_rd_tick & poll_q;
`endif
        end
    end

endmodule
